// File: rtl/dkong_pal_loader.sv
// Palette download writer: filters the ROM-download stream to the palette window,
// buffers accepted bytes and replays them into RAMs 2E/2F with a setup/strobe/hold write.
module dkong_pal_loader #(
  parameter logic [24:0] PAL_BASE   = 25'h0_4000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        CLK_12M,
  input  logic        I_RST,
  input  logic        I_DL_ACTIVE,
  input  logic        I_DL_WR,
  input  logic [24:0] I_DL_ADDR,
  input  logic [7:0]  I_DL_DATA,
  output logic        O_DL_WAIT,
  output logic [7:0]  O_CNF_A,
  output logic [7:0]  O_CNF_D,
  output logic        O_CNF_EN,
  output logic        O_WE2,
  output logic        O_WE3,
  output logic        O_DONE,
  output logic [9:0]  O_CNT,
  output logic [15:0] O_SUM,
  output logic        O_OVF
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // FIFO entry layout: {bank select, ram address, data}
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    d_q, d_d;
  logic          sel_q, sel_d;
  logic          we2_q, we2_d;
  logic          we3_q, we3_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          wait_q, wait_d;
  logic [9:0]    cnt_q, cnt_d;
  logic [15:0]   sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic          act_q;

  logic [24:0]   off;
  logic          accept;
  logic          rise;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [16:0]   head;
  logic [9:0]    cnt_base;
  logic [15:0]   sum_base;

  always_comb begin
    off        = I_DL_ADDR - PAL_BASE;
    accept     = I_DL_WR & I_DL_ACTIVE & (off < 25'd512);
    rise       = I_DL_ACTIVE & ~act_q;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    head       = mem_q[rd_ptr_q];

    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    sel_d   = sel_q;
    we2_d   = 1'b0;
    we3_d   = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = STROBE;
        we2_d   = ~sel_q;
        we3_d   = sel_q;
      end
      STROBE: state_d = HOLD;
      HOLD: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      {sel_d, a_d, d_d} = head;
    end

    // A full FIFO still takes a byte when the FSM pops in the same cycle.
    push = accept & (~fifo_full | pop);
    drop = accept & fifo_full & ~pop;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    wait_d = (count_d >= CW'(FIFO_DEPTH - 1));

    // Writes still in flight across a new download count into the new totals.
    cnt_base = rise ? 10'd0 : cnt_q;
    sum_base = rise ? 16'd0 : sum_q;
    cnt_d    = cnt_base;
    sum_d    = sum_base;
    if (state_q == STROBE) begin
      cnt_d = (cnt_base == 10'd1023) ? cnt_base : cnt_base + 10'd1;
      sum_d = sum_base + {8'd0, d_q};
    end
    ovf_d = (rise ? 1'b0 : ovf_q) | drop;

    en_d   = en_q;
    done_d = 1'b0;
    if (accept) begin
      en_d = 1'b1;
    end else if (en_q && state_q == IDLE && fifo_empty && !I_DL_ACTIVE) begin
      en_d   = 1'b0;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_12M) begin
    if (I_RST) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a_q      <= 8'd0;
      d_q      <= 8'd0;
      sel_q    <= 1'b0;
      we2_q    <= 1'b0;
      we3_q    <= 1'b0;
      en_q     <= 1'b0;
      done_q   <= 1'b0;
      wait_q   <= 1'b0;
      cnt_q    <= 10'd0;
      sum_q    <= 16'd0;
      ovf_q    <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a_q      <= a_d;
      d_q      <= d_d;
      sel_q    <= sel_d;
      we2_q    <= we2_d;
      we3_q    <= we3_d;
      en_q     <= en_d;
      done_q   <= done_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      ovf_q    <= ovf_d;
      act_q    <= I_DL_ACTIVE;
    end
  end

  always_ff @(posedge CLK_12M) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {off[8], off[7:0], I_DL_DATA};
    end
  end

  assign O_DL_WAIT = wait_q;
  assign O_CNF_A   = a_q;
  assign O_CNF_D   = d_q;
  assign O_CNF_EN  = en_q;
  assign O_WE2     = we2_q;
  assign O_WE3     = we3_q;
  assign O_DONE    = done_q;
  assign O_CNT     = cnt_q;
  assign O_SUM     = sum_q;
  assign O_OVF     = ovf_q;

endmodule

// File: tb/tb_dkong_pal_loader.sv
// Bench for dkong_pal_loader: drives download traffic, predicts every palette RAM
// write in a queue and checks strobes, counters, overflow and completion pulses.
module tb_dkong_pal_loader;

  localparam logic [24:0] PAL_BASE = 25'h0_4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        dl_active;
  logic        dl_wr;
  logic [24:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wait;
  logic [7:0]  cnf_a;
  logic [7:0]  cnf_d;
  logic        cnf_en;
  logic        we2;
  logic        we3;
  logic        done;
  logic [9:0]  cnt;
  logic [15:0] sum;
  logic        ovf;

  dkong_pal_loader #(.PAL_BASE(PAL_BASE), .FIFO_DEPTH(4)) dut (
    .CLK_12M    (clk),
    .I_RST      (rst),
    .I_DL_ACTIVE(dl_active),
    .I_DL_WR    (dl_wr),
    .I_DL_ADDR  (dl_addr),
    .I_DL_DATA  (dl_data),
    .O_DL_WAIT  (dl_wait),
    .O_CNF_A    (cnf_a),
    .O_CNF_D    (cnf_d),
    .O_CNF_EN   (cnf_en),
    .O_WE2      (we2),
    .O_WE3      (we3),
    .O_DONE     (done),
    .O_CNT      (cnt),
    .O_SUM      (sum),
    .O_OVF      (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [16:0] exp_q[$];
  int          exp_cnt = 0;
  logic [15:0] exp_sum = 16'd0;
  int          we2_n = 0;
  int          we3_n = 0;
  int          done_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    logic [16:0] e;
    if (we2 && we3) check("we_both", 1, 0);
    if (we2 || we3) begin
      if (we2) we2_n++;
      if (we3) we3_n++;
      if (exp_q.size() == 0) begin
        check("unexp_strobe", {15'd0, we3, cnf_a, cnf_d}, 32'h1_ffff);
      end else begin
        e = exp_q.pop_front();
        check("strobe", {15'd0, we3, cnf_a, cnf_d}, {15'd0, e});
        check("en_at_strobe", {31'd0, cnf_en}, 1);
        exp_cnt = exp_cnt + 1;
        exp_sum = exp_sum + {8'd0, e[7:0]};
      end
    end
    if (done) done_n++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dl();
    dl_active = 1'b1;
    exp_cnt   = 0;
    exp_sum   = 16'd0;
    tick();
  endtask

  task automatic send(input logic [24:0] addr, input logic [7:0] data);
    logic [24:0] off;
    int n;
    n = 0;
    while (dl_wait && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("wait_timeout", 1, 0);
    off     = addr - PAL_BASE;
    dl_wr   = 1'b1;
    dl_addr = addr;
    dl_data = data;
    if (dl_active && off < 25'd512) exp_q.push_back({off[8], off[7:0], data});
    tick();
    dl_wr = 1'b0;
  endtask

  task automatic end_dl_wait_done(input string tag);
    int start;
    int n;
    dl_active = 1'b0;
    start = done_n;
    n = 0;
    while (done_n == start && n < 3000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check({tag, "_done_once"}, done_n - start, 1);
    check({tag, "_en_clear"}, {31'd0, cnf_en}, 0);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int s2;
    int s3;
    int d0;
    rst       = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = 25'd0;
    dl_data   = 8'd0;
    repeat (3) tick();
    check("rst_en",   {31'd0, cnf_en}, 0);
    check("rst_we",   {30'd0, we2, we3}, 0);
    check("rst_a_d",  {16'd0, cnf_a, cnf_d}, 0);
    check("rst_cnt",  {22'd0, cnt}, 0);
    check("rst_sum",  {16'd0, sum}, 0);
    check("rst_misc", {29'd0, ovf, done, dl_wait}, 0);
    rst = 1'b0;
    tick();

    // Single byte into RAM 2E
    start_dl();
    send(PAL_BASE + 25'd5, 8'hA3);
    check("single_en_set", {31'd0, cnf_en}, 1);
    end_dl_wait_done("single");
    check("single_cnt", {22'd0, cnt}, 1);
    check("single_sum", {16'd0, sum}, 16'h00A3);

    // Bank select: upper 256 bytes go to RAM 2F
    s2 = we2_n;
    s3 = we3_n;
    start_dl();
    check("cnt_cleared", {22'd0, cnt}, 0);
    send(PAL_BASE + 25'd263, 8'h3C);
    end_dl_wait_done("bank");
    check("bank_we2", we2_n - s2, 0);
    check("bank_we3", we3_n - s3, 1);
    check("bank_cnt", {22'd0, cnt}, 1);

    // Full palette, sender honours backpressure
    s2 = we2_n;
    s3 = we3_n;
    start_dl();
    for (int i = 0; i < 512; i++) begin
      send(PAL_BASE + 25'(i), 8'(i));
    end
    end_dl_wait_done("full");
    check("full_we2", we2_n - s2, 256);
    check("full_we3", we3_n - s3, 256);
    check("full_cnt", {22'd0, cnt}, 512);
    check("full_cnt_model", {22'd0, cnt}, exp_cnt);
    check("full_sum", {16'd0, sum}, 16'hFF00);
    check("full_ovf", {31'd0, ovf}, 0);

    // Overflow: 8 back-to-back writes ignoring backpressure from an empty, idle
    // writer. Pops land on cycles 1 and 4 and 7, so the FIFO is full with no pop
    // when the 7th byte (index 6) arrives and only that byte is lost.
    start_dl();
    for (int i = 0; i < 8; i++) begin
      dl_wr   = 1'b1;
      dl_addr = PAL_BASE + 25'h40 + 25'(i);
      dl_data = 8'h50 + 8'(i);
      if (i != 6) exp_q.push_back({1'b0, 8'h40 + 8'(i), 8'h50 + 8'(i)});
      tick();
    end
    dl_wr = 1'b0;
    check("ovf_set", {31'd0, ovf}, 1);
    end_dl_wait_done("ovf");
    check("ovf_cnt", {22'd0, cnt}, 7);
    check("ovf_sum", {16'd0, sum}, exp_sum);
    check("ovf_sticky", {31'd0, ovf}, 1);
    start_dl();
    check("ovf_cleared", {31'd0, ovf}, 0);
    check("ovf_cnt_cleared", {22'd0, cnt}, 0);
    dl_active = 1'b0;
    repeat (5) tick();

    // Out-of-region writes are ignored entirely
    s2 = we2_n;
    s3 = we3_n;
    d0 = done_n;
    start_dl();
    send(PAL_BASE - 25'd1, 8'h11);
    send(PAL_BASE + 25'd512, 8'h22);
    check("oor_en", {31'd0, cnf_en}, 0);
    dl_active = 1'b0;
    repeat (30) tick();
    check("oor_strobes", (we2_n - s2) + (we3_n - s3), 0);
    check("oor_done", done_n - d0, 0);
    check("oor_en_end", {31'd0, cnf_en}, 0);

    // Reset during a strobe discards the rest of the buffer
    start_dl();
    send(PAL_BASE + 25'd1, 8'h71);
    send(PAL_BASE + 25'd2, 8'h72);
    send(PAL_BASE + 25'd3, 8'h73);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!(we2 || we3) && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("rst_strobe_timeout", 1, 0);
    end
    rst       = 1'b1;
    dl_active = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_we", {30'd0, we2, we3}, 0);
    check("midrst_en", {31'd0, cnf_en}, 0);
    check("midrst_cnt", {22'd0, cnt}, 0);
    rst = 1'b0;
    exp_q.delete();
    s2 = we2_n;
    s3 = we3_n;
    repeat (30) tick();
    check("midrst_no_writes", (we2_n - s2) + (we3_n - s3), 0);
    check("midrst_cnt_after", {22'd0, cnt}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
